// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: absorbs every offered byte, show-ahead read port, sticky overrun flag.
// Define UART_RX_FIFO_RTS_EN to build the registered rts_n flow-control output (else rts_n is tied 0).
module uart_rx_fifo #(
    parameter int PAYLOAD_BITS  = 8,
    parameter int DEPTH         = 8,
    parameter int RTS_THRESHOLD = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     rx_valid,
    input  logic [PAYLOAD_BITS-1:0]  rx_data,
    output logic                     rx_read,
    input  logic                     rd_en,
    output logic [PAYLOAD_BITS-1:0]  rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    input  logic                     overrun_clr,
    output logic                     rts_n
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Elaboration-time guard against unsupported geometry.
    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || RTS_THRESHOLD > DEPTH) begin : g_bad_cfg
        $error("uart_rx_fifo: DEPTH must be a power of two in 2..64 and RTS_THRESHOLD <= DEPTH");
    end

    logic [PAYLOAD_BITS-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [LVL_W-1:0]        level_r;
    logic [LVL_W-1:0]        level_next_s;
    logic                    overrun_r;
    logic                    full_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    drop_s;

    // Push/pop/drop decisions and next fill level.
    always_comb begin
        full_s       = (level_r == LVL_W'(DEPTH));
        pop_s        = rd_en && (level_r != {LVL_W{1'b0}});
        push_s       = rx_valid && (!full_s || pop_s);
        drop_s       = rx_valid && full_s && !pop_s;
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase
    end

    // The receiver is always released in the offer cycle; nothing is taken while in reset.
    assign rx_read  = rx_valid && resetn;
    assign rd_data  = mem_r[rd_ptr_r];
    assign rd_valid = (level_r != {LVL_W{1'b0}});
    assign level    = level_r;
    assign overrun  = overrun_r;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (resetn && push_s) begin
            mem_r[wr_ptr_r] <= rx_data;
        end
    end

    // Pointers, fill level and sticky overrun; a drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            level_r   <= {LVL_W{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_next_s;
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (overrun_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_RTS_EN
    // Flow control tracks the level the FIFO is about to hold, so it reacts in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rts_n <= 1'b1;
        end else begin
            rts_n <= (level_next_s >= LVL_W'(RTS_THRESHOLD));
        end
    end
`else
    assign rts_n = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH 8, 8-bit payload, RTS threshold 6).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_read;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] level;
    logic       overrun;
    logic       overrun_clr;
    logic       rts_n;

    int n_cmp = 0;
    int n_err = 0;

`ifdef UART_RX_FIFO_RTS_EN
    localparam bit RTS_ON = 1'b1;
`else
    localparam bit RTS_ON = 1'b0;
`endif

    uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH(8), .RTS_THRESHOLD(6)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_read     (rx_read),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .level       (level),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .rts_n       (rts_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic clr);
        rx_valid    = v;
        rx_data     = d;
        rd_en       = r;
        overrun_clr = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        logic [7:0] b;

        // Reset with a byte offered: must not be taken or stored.
        resetn = 1'b0;
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("rx_read_in_reset", 32'(rx_read), 32'd0);
        tick();
        tick();
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_rts_n", 32'(rts_n), RTS_ON ? 32'd1 : 32'd0);
        resetn = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_rts_n", 32'(rts_n), 32'd0);

        // Three pushes then three pops.
        exp_q = '{8'h11, 8'h22, 8'h33};
        foreach (exp_q[i]) begin
            drive(1'b1, exp_q[i], 1'b0, 1'b0);
            chk("rx_read_offer", 32'(rx_read), 32'd1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("three_level", 32'(level), 32'd3);
        chk("three_head", 32'(rd_data), 32'h11);
        chk("three_rd_valid", 32'(rd_valid), 32'd1);
        foreach (exp_q[i]) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("pop_data", 32'(rd_data), 32'(exp_q[i]));
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("drained_rd_valid", 32'(rd_valid), 32'd0);
        chk("drained_level", 32'(level), 32'd0);

        // Nine pushes into 8 entries: 0x08 dropped, overrun set; RTS around 5/6.
        for (int i = 0; i < 9; i++) begin
            b = 8'(i);
            drive(1'b1, b, 1'b0, 1'b0);
            tick();
            if (i == 4) chk("rts_at_5", 32'(rts_n), 32'd0);
            if (i == 5) begin
                chk("level_6", 32'(level), 32'd6);
                chk("rts_at_6", 32'(rts_n), RTS_ON ? 32'd1 : 32'd0);
            end
            if (i == 7) chk("overrun_not_yet", 32'(overrun), 32'd0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_level", 32'(level), 32'd8);
        chk("full_overrun", 32'(overrun), 32'd1);
        chk("full_head", 32'(rd_data), 32'h00);

        // Drop plus clear keeps overrun; clear alone clears it.
        drive(1'b1, 8'h99, 1'b0, 1'b1);
        tick();
        chk("drop_clr_overrun", 32'(overrun), 32'd1);
        chk("drop_clr_level", 32'(level), 32'd8);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        chk("clr_overrun", 32'(overrun), 32'd0);

        // Push while full with same-cycle pop.
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_pushpop_head", 32'(rd_data), 32'h00);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_pushpop_level", 32'(level), 32'd8);
        chk("full_pushpop_overrun", 32'(overrun), 32'd0);

        // Drain: 0x01..0x07 then 0xAA; RTS drops once level falls to 5.
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hAA};
        foreach (exp_q[i]) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data", 32'(rd_data), 32'(exp_q[i]));
            tick();
            if (i == 1) chk("rts_drain_6", 32'(rts_n), RTS_ON ? 32'd1 : 32'd0);
            if (i == 2) begin
                chk("drain_level_5", 32'(level), 32'd5);
                chk("rts_drain_5", 32'(rts_n), 32'd0);
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("drain_empty", 32'(rd_valid), 32'd0);

        // Read of empty FIFO is ignored; push + read at empty yields level 1.
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        chk("underflow_level", 32'(level), 32'd0);
        chk("underflow_rd_valid", 32'(rd_valid), 32'd0);
        drive(1'b1, 8'h5C, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("empty_pushpop_level", 32'(level), 32'd1);
        chk("empty_pushpop_data", 32'(rd_data), 32'h5C);

        // Reset mid-operation overrides a pending push and pop.
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        resetn = 1'b0;
        #1;
        chk("rx_read_reset_mid", 32'(rx_read), 32'd0);
        tick();
        resetn = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("midreset_level", 32'(level), 32'd0);
        chk("midreset_rd_valid", 32'(rd_valid), 32'd0);
        chk("midreset_rts_n", 32'(rts_n), RTS_ON ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
